imm_decode_queue: RTL and testbench

//  Decode-stage immediate generator with a valid/ready instruction queue. Accepts fetched
//  {insn, pc}, computes the sign-extended XLEN immediate, immediate type and illegal flag at

---
 rtl/imm_decode_queue_if.sv | 32 +++
 rtl/imm_decode_queue.sv | 188 ++++++++++++++++++
 tb/tb_imm_decode_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_queue_if.sv
// Bus bundle for imm_decode_queue.
//   Upstream side : in_valid_i, in_ready_o, insn_i, pc_i
//   Downstream side: out_valid_o, out_ready_i, insn_o, pc_o, imm_o, imm_type_o, illegal_o
//   master - the environment around the queue. It feeds instructions and consumes decoded entries.
//   slave  - the queue itself.
// The _i/_o suffixes are named from the queue's point of view.
interface imm_decode_queue_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       insn_i;
  logic [AWIDTH-1:0] pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       insn_o;
  logic [AWIDTH-1:0] pc_o;
  logic [XLEN-1:0]   imm_o;
  logic [2:0]        imm_type_o;
  logic              illegal_o;

  modport master (
    output in_valid_i, insn_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, insn_o, pc_o, imm_o, imm_type_o, illegal_o
  );

  modport slave (
    input  in_valid_i, insn_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, insn_o, pc_o, imm_o, imm_type_o, illegal_o
  );
endinterface

// File: rtl/imm_decode_queue.sv
// imm_decode_queue
// This is a decode-stage immediate generator placed in front of a small valid/ready FIFO.
// Each accepted {insn, pc} is decoded when it is enqueued. Decoding produces:
//   - an XLEN-wide sign-extended immediate
//   - the immediate type
//   - the illegal flag
// The decoded entry is then held until downstream consumes it.
// Ports:
//   clk      - clock; all state changes on the rising edge
//   rst      - synchronous, active-high reset
//   flush_i  - drops every queued entry and the entry being offered this cycle
//   bus_io   - imm_decode_queue_if.slave carrying both handshakes and the head entry
// Parameters:
//   XLEN       - 32 or 64
//   AWIDTH     - pc width
//   DEPTH      - number of queue entries; a power of two, at least 2
//   SHAMT_ZEXT - when 1, OP-IMM and OP-IMM-32 shifts return the zero-extended shamt
module imm_decode_queue #(
  parameter int XLEN       = 32,
  parameter int AWIDTH     = 32,
  parameter int DEPTH      = 2,
  parameter int SHAMT_ZEXT = 0
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush_i,
  imm_decode_queue_if.slave    bus_io
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  typedef struct packed {
    logic [31:0]       insn;
    logic [AWIDTH-1:0] pc;
    logic [XLEN-1:0]   imm;
    logic [2:0]        imm_type;
    logic              illegal;
  } entry_t;

  // Every RV32 immediate form keeps its sign in bit 31.
  // Widening to XLEN therefore replicates bit 31 into the upper bits.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // ---------------- decoder (enqueue side) ----------------
  logic [31:0]     insn;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;

  assign insn     = bus_io.insn_i;
  assign opcode   = insn[6:0];
  assign funct3   = insn[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    // All mapped opcodes end in 2'b11.
    // A compressed or garbage encoding therefore falls through to default and is flagged illegal.
    case (opcode)
      7'b0110111, 7'b0010111: begin  // LUI, AUIPC
        dec_type = T_U;
        dec_imm  = sext32({insn[31:12], 12'b0});
      end
      7'b1101111: begin  // JAL
        dec_type = T_J;
        dec_imm  = sext32({{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0});
      end
      7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: begin  // JALR, LOAD, MISC-MEM, SYSTEM
        dec_type = T_I;
        dec_imm  = sext32({{20{insn[31]}}, insn[31:20]});
      end
      7'b0010011: begin  // OP-IMM
        dec_type = T_I;
        if (SHAMT_ZEXT != 0 && is_shift) begin
          // On RV64 the shamt field is 6 bits wide; on RV32 it is 5 bits.
          if (XLEN == 64) dec_imm[5:0] = insn[25:20];
          else            dec_imm[4:0] = insn[24:20];
        end else begin
          dec_imm = sext32({{20{insn[31]}}, insn[31:20]});
        end
      end
      7'b0100011: begin  // STORE
        dec_type = T_S;
        dec_imm  = sext32({{20{insn[31]}}, insn[31:25], insn[11:7]});
      end
      7'b1100011: begin  // BRANCH
        dec_type = T_B;
        dec_imm  = sext32({{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0});
      end
      7'b0110011: begin  // OP: register-register, no immediate
        dec_type = T_NONE;
      end
      7'b0011011: begin  // OP-IMM-32, RV64 only
        if (XLEN == 64) begin
          dec_type = T_I;
          if (SHAMT_ZEXT != 0 && is_shift) dec_imm[4:0] = insn[24:20];
          else                             dec_imm = sext32({{20{insn[31]}}, insn[31:20]});
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0111011: begin  // OP-32, RV64 only
        if (XLEN != 64) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // ---------------- queue control ----------------
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic          enq, deq;

  // Ready depends only on occupancy.
  // A full queue refuses a new entry even if the head is leaving in the same cycle.
  assign bus_io.in_ready_o  = (count_q != FULL_CNT);
  assign bus_io.out_valid_o = (count_q != '0);
  assign enq = bus_io.in_valid_i  & bus_io.in_ready_o;
  assign deq = bus_io.out_valid_o & bus_io.out_ready_i;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps: DEPTH is a power of two
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (enq && !flush_i) begin
        mem_q[wr_ptr_q] <= '{insn:     insn,
                             pc:       bus_io.pc_i,
                             imm:      dec_imm,
                             imm_type: dec_type,
                             illegal:  dec_ill};
      end
    end
  end

  // The head is read combinationally.
  // When the queue is empty, the outputs show whatever slot rd_ptr points at.
  // That value is stale but stable.
  assign head               = mem_q[rd_ptr_q];
  assign bus_io.insn_o      = head.insn;
  assign bus_io.pc_o        = head.pc;
  assign bus_io.imm_o       = head.imm;
  assign bus_io.imm_type_o  = head.imm_type;
  assign bus_io.illegal_o   = head.illegal;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Bench for imm_decode_queue.
// Two instances see identical stimulus:
//   dut_a - XLEN=32, SHAMT_ZEXT=0
//   dut_b - XLEN=64, SHAMT_ZEXT=1
// A vector table streams instructions through both at one per cycle.
// Hand-written sequences then cover backpressure, full queue with simultaneous enq/deq, and flush.
module tb_imm_decode_queue;

  logic clk;
  logic rst;
  logic flush;

  imm_decode_queue_if #(.XLEN(32), .AWIDTH(32)) ifa ();
  imm_decode_queue_if #(.XLEN(64), .AWIDTH(32)) ifb ();

  imm_decode_queue #(.XLEN(32), .AWIDTH(32), .DEPTH(2), .SHAMT_ZEXT(0)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .bus_io(ifa.slave)
  );
  imm_decode_queue #(.XLEN(64), .AWIDTH(32), .DEPTH(2), .SHAMT_ZEXT(1)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .bus_io(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] imm32;
    logic [2:0]  ty32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  ty64;
    logic        ill64;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic ordy);
    ifa.in_valid_i = v;  ifa.insn_i = insn;  ifa.pc_i = pc;  ifa.out_ready_i = ordy;
    ifb.in_valid_i = v;  ifb.insn_i = insn;  ifb.pc_i = pc;  ifb.out_ready_i = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] INS_A = 32'h00100093;
  localparam logic [31:0] INS_B = 32'h00200093;
  localparam logic [31:0] INS_C = 32'h00300093;
  localparam logic [31:0] INS_E = 32'h00500093;

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h80000037, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[3]  = '{32'h4030D093, 32'h00000403, 3'd1, 1'b0, 64'h0000000000000003, 3'd1, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[5]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
    vecs[6]  = '{32'h00112623, 32'h0000000C, 3'd2, 1'b0, 64'h000000000000000C, 3'd2, 1'b0};
    vecs[7]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[8]  = '{32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0};
    vecs[9]  = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[10] = '{32'hFFF00091, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[11] = '{32'h4010D09B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0};
    vecs[12] = '{32'hFFF0D093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'h000000000000003F, 3'd1, 1'b0};
    vecs[13] = '{32'h12345117, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[14] = '{32'h80008067, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
    vecs[15] = '{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'h00000000000000FF, 3'd1, 1'b0};

    // ---- reset ----
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid_a", {63'b0, ifa.out_valid_o}, 64'd0);
    chk("rst in_ready_a",  {63'b0, ifa.in_ready_o},  64'd1);
    chk("rst out_valid_b", {63'b0, ifb.out_valid_o}, 64'd0);
    chk("rst in_ready_b",  {63'b0, ifb.in_ready_o},  64'd1);
    chk("rst insn_a",      {32'b0, ifa.insn_o},      64'd0);
    chk("rst pc_a",        {32'b0, ifa.pc_o},        64'd0);
    chk("rst imm_a",       {32'b0, ifa.imm_o},       64'd0);
    chk("rst imm_b",       ifb.imm_o,                64'd0);
    $display("reset: out_valid=%0b in_ready=%0b", ifa.out_valid_o, ifa.in_ready_o);
    rst = 1'b0;

    // ---- table: one entry per cycle ----
    // The entry accepted at an edge is the head right after that edge.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].insn, 32'h1000 + 32'(i * 4), 1'b1);
      tick();
      chk($sformatf("v%0d out_valid", i), {63'b0, ifa.out_valid_o}, 64'd1);
      chk($sformatf("v%0d insn_a", i),    {32'b0, ifa.insn_o}, {32'b0, vecs[i].insn});
      chk($sformatf("v%0d pc_a", i),      {32'b0, ifa.pc_o},   64'h1000 + 64'(i * 4));
      chk($sformatf("v%0d imm32", i),     {32'b0, ifa.imm_o},  {32'b0, vecs[i].imm32});
      chk($sformatf("v%0d type32", i),    {61'b0, ifa.imm_type_o}, {61'b0, vecs[i].ty32});
      chk($sformatf("v%0d ill32", i),     {63'b0, ifa.illegal_o},  {63'b0, vecs[i].ill32});
      chk($sformatf("v%0d imm64", i),     ifb.imm_o,               vecs[i].imm64);
      chk($sformatf("v%0d type64", i),    {61'b0, ifb.imm_type_o}, {61'b0, vecs[i].ty64});
      chk($sformatf("v%0d ill64", i),     {63'b0, ifb.illegal_o},  {63'b0, vecs[i].ill64});
      $display("vec %0d insn=%08h imm32=%08h t=%0d ill=%0b | imm64=%016h t=%0d ill=%0b",
               i, ifa.insn_o, ifa.imm_o, ifa.imm_type_o, ifa.illegal_o,
               ifb.imm_o, ifb.imm_type_o, ifb.illegal_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("drain out_valid", {63'b0, ifa.out_valid_o}, 64'd0);

    // ---- backpressure: A,B fill, C held, then released in order ----
    drive(1'b1, INS_A, 32'h2000, 1'b0);
    tick();
    chk("bp A head",     {32'b0, ifa.insn_o},     {32'b0, INS_A});
    chk("bp A in_ready", {63'b0, ifa.in_ready_o}, 64'd1);
    drive(1'b1, INS_B, 32'h2004, 1'b0);
    tick();
    chk("bp full in_ready", {63'b0, ifa.in_ready_o}, 64'd0);
    chk("bp full head",     {32'b0, ifa.insn_o},     {32'b0, INS_A});
    drive(1'b1, INS_C, 32'h2008, 1'b0);
    tick();
    chk("bp C held in_ready", {63'b0, ifa.in_ready_o}, 64'd0);
    chk("bp C held head",     {32'b0, ifa.insn_o},     {32'b0, INS_A});
    $display("backpressure: full, head=%08h", ifa.insn_o);
    // Full queue with enq and deq offered together: only the dequeue happens.
    drive(1'b1, INS_C, 32'h2008, 1'b1);
    tick();
    chk("full deq head B",   {32'b0, ifa.insn_o},      {32'b0, INS_B});
    chk("full deq in_ready", {63'b0, ifa.in_ready_o},  64'd1);
    chk("full deq valid",    {63'b0, ifa.out_valid_o}, 64'd1);
    tick();  // C enqueued while B leaves
    chk("release head C",    {32'b0, ifa.insn_o},  {32'b0, INS_C});
    chk("release pc C",      {32'b0, ifa.pc_o},    64'h2008);
    chk("release C valid",   {63'b0, ifa.out_valid_o}, 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("release empty", {63'b0, ifa.out_valid_o}, 64'd0);
    $display("backpressure: released A,B,C");

    // ---- flush with a full queue and an incoming entry ----
    drive(1'b1, INS_A, 32'h3000, 1'b0);
    tick();
    drive(1'b1, INS_B, 32'h3004, 1'b0);
    tick();
    chk("flush pre full", {63'b0, ifa.in_ready_o}, 64'd0);
    flush = 1'b1;
    drive(1'b1, INS_C, 32'h3008, 1'b1);
    tick();
    flush = 1'b0;
    chk("flush out_valid_a", {63'b0, ifa.out_valid_o}, 64'd0);
    chk("flush out_valid_b", {63'b0, ifb.out_valid_o}, 64'd0);
    chk("flush in_ready",    {63'b0, ifa.in_ready_o},  64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("flush dropped", {63'b0, ifa.out_valid_o}, 64'd0);
    drive(1'b1, INS_E, 32'h300C, 1'b1);
    tick();
    chk("post flush head",  {32'b0, ifa.insn_o},      {32'b0, INS_E});
    chk("post flush valid", {63'b0, ifa.out_valid_o}, 64'd1);
    chk("post flush imm",   {32'b0, ifa.imm_o},       64'd5);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    $display("flush: queue emptied, next entry head=%08h", INS_E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
